// File: rtl/fec_stream_decoder.sv
// fec_stream_decoder: receive-side FEC block decoder.
// Loads M parity-stripped symbols and restores even parity on each one.
// Each output row is the XOR over columns of coef[row][col] * buf[col],
// computed in the cyclic-shift ring GF(2)[x]/(x^WIDTH - 1), one product per cycle.
module fec_stream_decoder #(
    parameter int M      = 3,
    parameter int WIDTH  = 11,
    parameter int DATA_W = WIDTH - 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_W-1:0]                   in_data,
    input  logic [M-1:0][M-1:0][WIDTH-1:0]      dec_coeffs,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_W-1:0]                   out_data,
    output logic                                out_err,
    output logic                                out_last
);

    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

    typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

    state_t                           state, state_nx;
    logic [IW-1:0]                    sym_idx, row, col;
    logic [WIDTH-1:0]                 acc, next_acc;
    logic [M-1:0][WIDTH-1:0]          sym_buf;
    logic [M-1:0][M-1:0][WIDTH-1:0]   coef;
    logic                             accept;

    // Ring product: XOR of s rotated left by every set bit position of c.
    function automatic logic [WIDTH-1:0] ring_mul(input logic [WIDTH-1:0] c,
                                                  input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (c[i]) r = r ^ ((s << i) | (s >> (WIDTH - i)));
        end
        return r;
    endfunction

    assign in_ready  = (state == LOAD) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == OUTPUT);

    // Accumulator value after this cycle's coefficient-symbol product.
    always_comb begin
        next_acc = acc ^ ring_mul(coef[row][col], sym_buf[col]);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nx;
    end

    // Next-state logic: load M symbols, then per row M products and one output beat.
    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (accept && sym_idx == LAST_IDX) state_nx = COMPUTE;
            COMPUTE: if (col == LAST_IDX)               state_nx = OUTPUT;
            OUTPUT:  if (out_ready)                     state_nx = (row == LAST_IDX) ? LOAD : COMPUTE;
            default:                                    state_nx = LOAD;
        endcase
    end

    // Datapath: symbol buffer, coefficient latch, counters, accumulator, output regs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_idx  <= '0;
            row      <= '0;
            col      <= '0;
            acc      <= '0;
            sym_buf  <= '0;
            coef     <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
            out_last <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        sym_buf[sym_idx] <= {^in_data, in_data};
                        if (sym_idx == '0) coef <= dec_coeffs;
                        if (sym_idx == LAST_IDX) begin
                            sym_idx <= '0;
                            row     <= '0;
                            col     <= '0;
                            acc     <= '0;
                        end else begin
                            sym_idx <= sym_idx + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    acc <= next_acc;
                    if (col == LAST_IDX) begin
                        out_data <= next_acc[DATA_W-1:0];
                        out_err  <= next_acc[WIDTH-1];
                        out_last <= (row == LAST_IDX);
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (out_ready && row != LAST_IDX) begin
                        row <= row + 1'b1;
                        col <= '0;
                        acc <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fec_stream_decoder.sv
// Testbench for fec_stream_decoder: directed vector table, multi-cycle corner
// sequences (backpressure, coefficient latching, mid-block reset, back-to-back)
// and randomized blocks checked against a polynomial-arithmetic reference model.
module tb_fec_stream_decoder;

    localparam int M      = 3;
    localparam int WIDTH  = 11;
    localparam int DATA_W = WIDTH - 1;

    typedef logic [M-1:0][M-1:0][WIDTH-1:0] coef_t;
    typedef logic [M-1:0][DATA_W-1:0]       syms_t;

    typedef struct {
        coef_t        co;
        syms_t        ins;
        syms_t        exp_d;
        logic [M-1:0] exp_e;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    coef_t             dec_coeffs;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err;
    logic              out_last;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int ref_cyc = 0;
    int last_e0 = 0;

    fec_stream_decoder #(.M(M), .WIDTH(WIDTH), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .dec_coeffs (dec_coeffs),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: restore even parity, then multiply polynomials and
    // fold the high half back modulo x^WIDTH - 1.
    function automatic logic [WIDTH-1:0] restore(input logic [DATA_W-1:0] d);
        logic [WIDTH-1:0] w;
        w = {1'b0, d};
        if ($countones(d) % 2 == 1) w[WIDTH-1] = 1'b1;
        return w;
    endfunction

    function automatic logic [WIDTH-1:0] poly_mod_mul(input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] p;
        logic [2*WIDTH-1:0] bw;
        p  = '0;
        bw = {{WIDTH{1'b0}}, b};
        for (int i = 0; i < WIDTH; i++)
            if (a[i]) p = p ^ (bw << i);
        return p[WIDTH-1:0] ^ p[2*WIDTH-1:WIDTH];
    endfunction

    task automatic model(input coef_t co, input syms_t ins,
                         output syms_t ed, output logic [M-1:0] ee);
        logic [WIDTH-1:0] s;
        for (int r = 0; r < M; r++) begin
            s = '0;
            for (int c = 0; c < M; c++) s = s ^ poly_mod_mul(co[r][c], restore(ins[c]));
            ed[r] = s[DATA_W-1:0];
            ee[r] = s[WIDTH-1];
        end
    endtask

    task automatic send_block(input coef_t co, input syms_t ins, input bit chg, input coef_t alt);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < M && guard < 100) begin
            @(negedge clk);
            if (i == 0) dec_coeffs = co;
            else if (chg) dec_coeffs = alt;
            in_valid = 1'b1;
            in_data  = ins[i];
            if (in_ready) begin
                if (i == M - 1) begin
                    ref_cyc = cyc + 1;
                    last_e0 = cyc + 1;
                end
                i++;
            end
            guard++;
        end
        if (i < M) check("send_timeout", i, M);
    endtask

    task automatic recv_row(input int r, input logic [DATA_W-1:0] ed, input logic ee, input int stall);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!out_valid && waited < 60) begin
            check("in_ready_busy", in_ready, 0);
            waited++;
            @(negedge clk);
        end
        if (!out_valid) begin
            check("out_valid_timeout", out_valid, 1);
            return;
        end
        check("row_latency", cyc - ref_cyc, M);
        check("out_data", out_data, ed);
        check("out_err", out_err, ee);
        check("out_last", out_last, (r == M - 1));
        check("in_ready_output", in_ready, 0);
        if (stall > 0) begin
            out_ready = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, ed);
                check("stall_err", out_err, ee);
                check("stall_last", out_last, (r == M - 1));
                check("stall_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
        end
        ref_cyc = cyc + 1;
        @(posedge clk);
    endtask

    task automatic run_block(input coef_t co, input syms_t ins, input syms_t ed, input logic [M-1:0] ee,
                             input int stall_row, input int stall_len, input bit chg, input coef_t alt);
        send_block(co, ins, chg, alt);
        for (int r = 0; r < M; r++)
            recv_row(r, ed[r], ee[r], (r == stall_row) ? stall_len : 0);
    endtask

    vec_t vecs[4];

    initial begin
        coef_t        co, alt;
        syms_t        ins, ed;
        logic [M-1:0] ee;
        int           e0a;

        // Directed vectors with hand-derived expectations
        for (int k = 0; k < 4; k++) begin
            vecs[k].co = '0; vecs[k].ins = '0; vecs[k].exp_d = '0; vecs[k].exp_e = '0;
        end
        // identity
        vecs[0].co[0][0] = 11'h001; vecs[0].co[1][1] = 11'h001; vecs[0].co[2][2] = 11'h001;
        vecs[0].ins[0] = 10'h003; vecs[0].ins[1] = 10'h3FF; vecs[0].ins[2] = 10'h155;
        vecs[0].exp_d[0] = 10'h003; vecs[0].exp_d[1] = 10'h3FF; vecs[0].exp_d[2] = 10'h155;
        vecs[0].exp_e = 3'b100;
        // rotation by one
        vecs[1].co[0][0] = 11'h002;
        vecs[1].ins[0] = 10'h081; vecs[1].ins[1] = 10'h2AA; vecs[1].ins[2] = 10'h011;
        vecs[1].exp_d[0] = 10'h102;
        // XOR accumulate
        vecs[2].co[0][0] = 11'h001; vecs[2].co[0][1] = 11'h001;
        vecs[2].ins[0] = 10'h003; vecs[2].ins[1] = 10'h005;
        vecs[2].exp_d[0] = 10'h006;
        // wraparound rotation, x^10+1 self-product, all-ones coefficient
        vecs[3].co[0][1] = 11'h004; vecs[3].co[1][2] = 11'h401; vecs[3].co[2][0] = 11'h7FF;
        vecs[3].ins[0] = 10'h001; vecs[3].ins[1] = 10'h3FF; vecs[3].ins[2] = 10'h001;
        vecs[3].exp_d[0] = 10'h3FD; vecs[3].exp_d[1] = 10'h201; vecs[3].exp_d[2] = 10'h000;
        vecs[3].exp_e = 3'b001;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; dec_coeffs = '0;
        repeat (3) @(negedge clk);
        check("in_ready_in_reset", in_ready, 0);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_err", out_err, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 1);

        // Directed table
        for (int k = 0; k < 4; k++)
            run_block(vecs[k].co, vecs[k].ins, vecs[k].exp_d, vecs[k].exp_e, -1, 0, 1'b0, '0);

        // Backpressure on row 1 with coefficients changed after symbol 0
        alt = '1;
        run_block(vecs[3].co, vecs[3].ins, vecs[3].exp_d, vecs[3].exp_e, 1, 7, 1'b1, alt);

        // Reset during the second COMPUTE row
        send_block(vecs[0].co, vecs[0].ins, 1'b0, '0);
        recv_row(0, vecs[0].exp_d[0], vecs[0].exp_e[0], 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_err", out_err, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_in_ready", in_ready, 1);
        run_block(vecs[1].co, vecs[1].ins, vecs[1].exp_d, vecs[1].exp_e, -1, 0, 1'b0, '0);

        // Back-to-back blocks: period between last-symbol acceptances
        run_block(vecs[0].co, vecs[0].ins, vecs[0].exp_d, vecs[0].exp_e, -1, 0, 1'b0, '0);
        e0a = last_e0;
        run_block(vecs[2].co, vecs[2].ins, vecs[2].exp_d, vecs[2].exp_e, -1, 0, 1'b0, '0);
        check("block_period", last_e0 - e0a, M + M * (M + 1));

        // Randomized blocks against the reference model
        for (int n = 0; n < 30; n++) begin
            for (int r = 0; r < M; r++)
                for (int c = 0; c < M; c++) begin
                    co[r][c]  = WIDTH'($urandom);
                    if ($urandom_range(0, 3) == 0) co[r][c] = '0;
                    alt[r][c] = WIDTH'($urandom);
                end
            for (int c = 0; c < M; c++) ins[c] = DATA_W'($urandom);
            model(co, ins, ed, ee);
            run_block(co, ins, ed, ee, int'($urandom_range(0, M)), int'($urandom_range(0, 4)),
                      bit'($urandom_range(0, 1)), alt);
        end

        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
